// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: write pointer, Gray export, read-pointer sync, full/level/overflow.
// wen is combinational from winc; all flags registered; pushes while full are dropped and flagged in wovf.
module fifo_wr_ctrl #(
  parameter int ASIZE       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 12
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic             wovf_clr,
  input  logic [ASIZE:0]   rptr_gray,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr_gray,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             wovf
);

  localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_THRESH);

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_next;
  logic [ASIZE:0] rq;
  logic [ASIZE:0] rbin_s;
  logic [ASIZE:0] level_next;
  logic           full_next;
  logic [ASIZE:0] sync_q [SYNC_STAGES];

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ASIZE-1:0];
  assign rq    = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      rbin_s[i] = ^(rq >> i);
    end
  end

  always_comb begin
    wbin_next  = wbin + {{ASIZE{1'b0}}, wen};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    level_next = wbin_next - rbin_s;
    // Full when the write pointer is exactly one lap ahead of the synced read pointer.
    full_next  = (wgray_next == {~rq[ASIZE:ASIZE-1], rq[ASIZE-2:0]});
  end

  // Plain flop chain: no logic between stages so only one Gray bit can be metastable.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= full_next;
      walmost_full <= (level_next >= AF_LVL);
      wlevel       <= level_next;
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: write addresses checked by a wen-driven monitor against a queue.
module tb_fifo_wr_ctrl;

  logic       wclk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic       wovf_clr;
  logic [4:0] rptr_gray;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  fifo_wr_ctrl #(.ASIZE(4), .SYNC_STAGES(2), .AF_THRESH(12)) dut (
    .wclk(wclk), .rst_n(rst_n), .winc(winc), .wovf_clr(wovf_clr),
    .rptr_gray(rptr_gray), .wen(wen), .waddr(waddr), .wptr_gray(wptr_gray),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // Monitor: every accepted write must match the next expected address.
  always @(negedge wclk) begin
    if (wen === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got waddr %0d expected no write", waddr);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (waddr !== e) begin
          bad++;
          $display("FAIL wr_addr: got %0d expected %0d", waddr, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] prev;
    rst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; rptr_gray = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_waddr", waddr, 0);
    check("rst_wen", wen, 0);
    check("rst_gray", wptr_gray, 0);
    check("rst_level", wlevel, 0);

    // Seven writes, then reset mid-stream.
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(4'(i));
      winc = 1'b1;
      step();
    end
    winc = 1'b0;
    check("pre_rst_waddr", waddr, 7);
    check("pre_rst_gray", wptr_gray, 5'b00100);
    check("pre_rst_level", wlevel, 7);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_waddr", waddr, 0);
    check("mid_rst_gray", wptr_gray, 0);
    check("mid_rst_level", wlevel, 0);
    check("mid_rst_full", wfull, 0);
    check("mid_rst_af", walmost_full, 0);
    check("mid_rst_wen", wen, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("post_rst_waddr", waddr, 0);
    check("post_rst_gray", wptr_gray, 0);

    // Fill 16 with the reader idle.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(4'(i));
      winc = 1'b1;
      step();
      check("fill_level", wlevel, i + 1);
      if (i == 10) check("af_before", walmost_full, 0);
      if (i == 11) check("af_rise", walmost_full, 1);
      if (i == 14) check("full_before", wfull, 0);
    end
    winc = 1'b0;
    check("fill_full", wfull, 1);
    check("fill_level16", wlevel, 16);
    check("fill_gray", wptr_gray, 5'b11000);

    // Overflow for two cycles.
    winc = 1'b1;
    #1;
    check("ovf_wen", wen, 0);
    step();
    check("ovf_set", wovf, 1);
    check("ovf_waddr", waddr, 0);
    step();
    winc = 1'b0;
    check("ovf_hold_waddr", waddr, 0);
    check("ovf_hold_gray", wptr_gray, 5'b11000);
    wovf_clr = 1'b1;
    step();
    wovf_clr = 1'b0;
    check("ovf_clr", wovf, 0);

    // Set and clear on the same edge: set wins.
    winc = 1'b1;
    step();
    check("sim_set", wovf, 1);
    wovf_clr = 1'b1;
    step();
    check("sim_set_wins", wovf, 1);
    winc = 1'b0;
    step();
    wovf_clr = 1'b0;
    check("sim_clr", wovf, 0);

    // Reader advances by one: full drops three edges later.
    rptr_gray = 5'b00001;
    step();
    check("rel_full_e1", wfull, 1);
    step();
    check("rel_full_e2", wfull, 1);
    check("rel_level_e2", wlevel, 16);
    step();
    check("rel_full_e3", wfull, 0);
    check("rel_level_e3", wlevel, 15);

    // Wrap: reader follows four writes behind.
    rst_n = 1'b0;
    rptr_gray = '0;
    step();
    rst_n = 1'b1;
    step();
    prev = wptr_gray;
    for (int e = 1; e <= 70; e++) begin
      exp_q.push_back(4'((e - 1) % 16));
      winc = 1'b1;
      step();
      rptr_gray = (e >= 4) ? gray(e - 4) : 5'b0;
      check("wrap_gray", wptr_gray, gray(e));
      check("wrap_onehot", $countones(wptr_gray ^ prev), 1);
      check("wrap_full", wfull, 0);
      if (e >= 4) check("wrap_lvl_range", (wlevel >= 4 && wlevel <= 7) ? 1 : 0, 1);
      if (e % 32 == 0) begin
        check("wrap_prev", prev, 5'b10000);
        check("wrap_zero", wptr_gray, 5'b00000);
      end
      prev = wptr_gray;
    end
    winc = 1'b0;
    step();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller of the asynchronous FIFO, running in the write clock domain. It accepts push requests and generates wen/waddr for the dual-port memory. It maintains binary and Gray write pointers and synchronizes the read-domain Gray pointer into wclk. From these it produces full, almost-full, fill level and a sticky overflow flag.

Parameters:
ASIZE, 4, memory address bits; FIFO depth = 2^ASIZE
SYNC_STAGES, 2, flops in the rptr_gray synchronizer chain; legal range 2..4
AF_THRESH, 12, walmost_full asserts when the level is >= AF_THRESH; legal range 1..2^ASIZE

Ports:
wclk  in  1  write clock
rst_n  in  1  reset: asynchronous, active-low
winc  in  1  push request from the writer
wovf_clr  in  1  synchronous clear of the sticky overflow flag
rptr_gray  in  ASIZE+1  read pointer in Gray code, from the read domain (asynchronous to wclk)
wen  out  1  memory write enable
waddr  out  ASIZE  memory write address
wptr_gray  out  ASIZE+1  registered Gray write pointer, sent to the read domain
wfull  out  1  FIFO full
walmost_full  out  1  level >= AF_THRESH
wlevel  out  ASIZE+1  conservative fill level, 0..2^ASIZE
wovf  out  1  sticky flag: a push was attempted while full

Behaviour:
- Reset (rst_n=0, asynchronous) clears to zero: wbin, wptr_gray, every synchronizer stage, wfull, walmost_full, wlevel and wovf. Consequences:
  - waddr=0.
  - wen=0 while winc=0.
- wen = winc & ~wfull. This is combinational and is the only combinational output.
- waddr = wbin[ASIZE-1:0]. wbin is an internal ASIZE+1-bit binary pointer.
- On each wclk edge:
  - wbin_next = wbin + wen, modulo 2^(ASIZE+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - wbin <= wbin_next; wptr_gray <= wgray_next.
  - wptr_gray changes by at most one bit per cycle.
- Synchronizer:
  - rptr_gray passes through SYNC_STAGES flops clocked by wclk. rq denotes the last stage.
  - No logic is allowed between stages.
- Full flag:
  - wfull <= (wgray_next == {~rq[ASIZE:ASIZE-1], rq[ASIZE-2:0]}), i.e. the top two bits are inverted and the rest are equal.
  - wfull is registered and asserts on the same edge that accepts the 2^ASIZE-th unread word.
  - It deasserts SYNC_STAGES+1 edges after rptr_gray advances.
- Level:
  - rbin_s = Gray-to-binary of rq.
  - wlevel <= wbin_next - rbin_s, as an (ASIZE+1)-bit modular subtraction.
  - wlevel is pessimistic: it never under-reports the true occupancy.
  - walmost_full <= (wbin_next - rbin_s) >= AF_THRESH.
- Overflow:
  - If winc=1 and wfull=1, no write occurs and wbin holds.
  - wovf <= 1 on that edge.
  - wovf_clr=1 clears wovf on the next edge. If a set and a clear occur on the same edge, set wins.
- Simultaneous push and read-pointer advance: both are applied. The level is computed from wbin_next and the current rq.
- Wrap-around: wbin wraps 2^(ASIZE+1)-1 -> 0 with no glitch in wptr_gray; the full and level math remain correct across the wrap.
- Reset mid-operation: all state clears immediately. wen is forced to 0 during reset only via wfull/winc, so the writer must hold winc=0 while rst_n=0.
- Latency: a write is accepted in the same cycle as winc (via wen). wptr_gray is visible at the output one edge later.

Test Plan:
- Reset: apply rst_n=0 mid-stream with wbin=7 -> all outputs 0 immediately; after release, waddr=0, wptr_gray=00000.
- Fill (ASIZE=4, rptr_gray=0): 16 consecutive winc cycles -> waddr 0..15, wen=1 on each. Also:
  - walmost_full rises on the edge of the 12th write.
  - wfull=1 after the 16th edge.
  - wlevel=16 and wptr_gray=11000.
- Overflow: with FIFO full, winc=1 for 2 cycles -> wen=0, waddr holds 0, wovf=1; one cycle of wovf_clr=1 -> wovf=0.
- Release: with FIFO full, set rptr_gray=00001 -> wfull=0 and wlevel=15 exactly 3 edges later (SYNC_STAGES=2).
- Wrap: continuous push with rptr_gray tracking wptr_gray delayed by 4 writes, for 70 writes. Checks:
  - waddr sequence is modulo 16.
  - wptr_gray passes 10000 -> 00000 with single-bit changes.
  - wfull is never set.
  - wlevel is always in the range 4..7.
- Simultaneous: on one edge, winc=1 at full and wovf_clr=1 -> wovf stays 1.
